// File: rtl/tof_pkg.sv
// rtl/tof_pkg.sv - shared FSM state, mode encoding and width helpers for the ToF frame sequencer
package tof_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } tof_state_t;

    localparam logic MODE_PLANE = 1'b0;
    localparam logic MODE_FULL  = 1'b1;

    function automatic int sens_w(input int n_sens);
        return $clog2(n_sens);
    endfunction

    function automatic int grid_w(input int grid);
        return $clog2(grid);
    endfunction

    function automatic int addr_w(input int n_sens, input int grid);
        return sens_w(n_sens) + 2 * grid_w(grid);
    endfunction
endpackage

// File: rtl/tof_frame_sequencer_if.sv
// rtl/tof_frame_sequencer_if.sv - output beat stream of the ToF frame sequencer
interface tof_frame_sequencer_if #(
    parameter int DW     = 16,
    parameter int N_SENS = 8
);
    import tof_pkg::*;

    localparam int SW = sens_w(N_SENS);

    logic [DW-1:0] out_data;
    logic [SW-1:0] out_sens;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (output out_data, output out_sens, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_sens, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/tof_out_fifo.sv
// rtl/tof_out_fifo.sv - synchronous FIFO with occupancy count, buffers BRAM read beats
module tof_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/tof_frame_sequencer.sv
// rtl/tof_frame_sequencer.sv - scans a ToF frame out of BRAM with credit-limited reads
// TOF_SENS_MASK_EN adds a sens_mask input that skips disabled sensors.
module tof_frame_sequencer
    import tof_pkg::*;
#(
    parameter int N_SENS   = 8,
    parameter int GRID     = 8,
    parameter int DW       = 16,
    parameter int BRAM_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             drdy,
    input  logic                             mode,
    input  logic [$clog2(GRID)-1:0]          plane_row,
`ifdef TOF_SENS_MASK_EN
    input  logic [N_SENS-1:0]                sens_mask,
`endif
    output logic [addr_w(N_SENS, GRID)-1:0]  data_addr,
    output logic                             rd_en,
    input  logic [DW-1:0]                    rd_data,
    tof_frame_sequencer_if.master            stream,
    output logic                             busy,
    output logic                             frame_done
);
    localparam int SW    = sens_w(N_SENS);
    localparam int GW    = grid_w(GRID);
    localparam int DEPTH = BRAM_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FW    = 1 + SW + DW;

    tof_state_t          state;
    logic                mode_s;
    logic [GW-1:0]       row_s;
    logic [N_SENS-1:0]   mask_s;
    logic [N_SENS-1:0]   mask_in;
    logic [SW-1:0]       sens;
    logic [GW-1:0]       row;
    logic [GW-1:0]       col;
    logic [SW:0]         first_sens;
    logic [SW:0]         nxt_sens;
    logic                last_addr;
    logic [BRAM_LAT-1:0] vpipe;
    logic [BRAM_LAT-1:0] lpipe;
    logic [SW-1:0]       spipe [BRAM_LAT];
    logic [CW-1:0]       occ;
    logic [3:0]          outstanding;
    logic                fifo_empty;
    logic [FW-1:0]       fifo_rdata;
    logic                pop;

`ifdef TOF_SENS_MASK_EN
    assign mask_in = sens_mask;
`else
    assign mask_in = '1;
`endif

    // Lowest enabled sensor index >= start; N_SENS (top bit set) when none remain.
    function automatic logic [SW:0] first_from(input logic [N_SENS-1:0] m, input int start);
        logic [SW:0] r;
        r = (SW+1)'(N_SENS);
        for (int i = N_SENS - 1; i >= 0; i--)
            if (i >= start && m[i]) r = (SW+1)'(i);
        return r;
    endfunction

    assign first_sens = first_from(mask_in, 0);
    assign nxt_sens   = first_from(mask_s, int'(sens) + 1);
    assign last_addr  = (col == GW'(GRID - 1)) && (mode_s == MODE_PLANE || row == GW'(GRID - 1)) && nxt_sens[SW];

    // Reads in the latency pipe plus FIFO entries bound how many beats can still land.
    always_comb begin
        outstanding = 4'(occ);
        for (int i = 0; i < BRAM_LAT; i++) outstanding = outstanding + 4'(vpipe[i]);
    end

    assign rd_en     = (state == ISSUE) && (mask_s != '0) && (outstanding < 4'(DEPTH));
    assign data_addr = {sens, row, col};
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign pop       = !fifo_empty && stream.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= rd_en;
            spipe[0] <= sens;
            lpipe[0] <= last_addr;
            for (int i = 1; i < BRAM_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                spipe[i] <= spipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    tof_out_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vpipe[BRAM_LAT-1]),
        .wdata ({lpipe[BRAM_LAT-1], spipe[BRAM_LAT-1], rd_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (occ)
    );

    assign stream.out_valid = !fifo_empty;
    assign stream.out_last  = fifo_rdata[FW-1];
    assign stream.out_sens  = fifo_rdata[DW +: SW];
    assign stream.out_data  = fifo_rdata[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_s     <= MODE_PLANE;
            row_s      <= '0;
            mask_s     <= '0;
            sens       <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (drdy) begin
                    state  <= ISSUE;
                    mode_s <= mode;
                    row_s  <= plane_row;
                    mask_s <= mask_in;
                    sens   <= first_sens[SW-1:0];
                    row    <= (mode == MODE_FULL) ? '0 : plane_row;
                    col    <= '0;
                end
                ISSUE: if (mask_s == '0) begin
                    state      <= RELEASE;
                    frame_done <= 1'b1;
                end else if (rd_en) begin
                    if (last_addr) begin
                        state <= DRAIN;
                        sens  <= '0;
                        row   <= '0;
                        col   <= '0;
                    end else if (col != GW'(GRID - 1)) begin
                        col <= col + 1'b1;
                    end else begin
                        col <= '0;
                        if (mode_s == MODE_FULL && row != GW'(GRID - 1)) begin
                            row <= row + 1'b1;
                        end else begin
                            row  <= (mode_s == MODE_FULL) ? '0 : row_s;
                            sens <= nxt_sens[SW-1:0];
                        end
                    end
                end
                DRAIN: if (pop && fifo_rdata[FW-1]) begin
                    state      <= RELEASE;
                    frame_done <= 1'b1;
                end
                RELEASE: if (!drdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tof_frame_sequencer.sv
// tb/tb_tof_frame_sequencer.sv - randomized bench against a behavioural frame model; TOF_SENS_MASK_EN adds mask cases
`timescale 1ns/1ps
module tb_tof_frame_sequencer;
    localparam int N_SENS = 8;
    localparam int GRID   = 8;
    localparam int DW     = 16;
    localparam int LAT    = 3;
    localparam int SW     = $clog2(N_SENS);
    localparam int GW     = $clog2(GRID);
    localparam int AW     = SW + 2 * GW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              drdy = 1'b0;
    logic              mode = 1'b0;
    logic [GW-1:0]     plane_row = '0;
    logic [N_SENS-1:0] sens_mask = '1;
    logic [AW-1:0]     data_addr;
    logic              rd_en;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              frame_done;

    tof_frame_sequencer_if #(.DW(DW), .N_SENS(N_SENS)) st ();

    tof_frame_sequencer #(.N_SENS(N_SENS), .GRID(GRID), .DW(DW), .BRAM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .drdy       (drdy),
        .mode       (mode),
        .plane_row  (plane_row),
`ifdef TOF_SENS_MASK_EN
        .sens_mask  (sens_mask),
`endif
        .data_addr  (data_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .stream     (st),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input int a);
        return DW'(a * 40503 + 4660);
    endfunction

    // BRAM: data for the strobed address appears LAT cycles later, noise otherwise.
    logic [DW-1:0] bq [LAT];
    always @(posedge clk) begin
        bq[0] <= rd_en ? mem_val(int'(data_addr)) : DW'($urandom);
        for (int i = 1; i < LAT; i++) bq[i] <= bq[i-1];
    end
    assign rd_data = bq[LAT-1];

    int tests = 0, fails = 0, cyc = 0;
    bit active = 0, rel = 0, done_next = 0;
    int total = 0, issued = 0, popped = 0, rdy_n = 0;
    int addr_q[$];
    int rd_cyc[$];
    int done_cnt = 0, beats_seen = 0, last_cnt = 0, max_out = 0, dut_out = 0;
    int first_rd = -1, first_ov = -1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build_frame(input bit m, input int r, input logic [N_SENS-1:0] msk);
        addr_q.delete();
        for (int s = 0; s < N_SENS; s++)
            for (int rr = 0; rr < GRID; rr++)
                for (int c = 0; c < GRID; c++)
                    if (msk[s] && (m || rr == r)) addr_q.push_back(s * GRID * GRID + rr * GRID + c);
        total = addr_q.size();
    endtask

    // Outputs settle by the falling edge and inputs hold until after the next rising edge,
    // so each falling edge checks the current cycle and then steps the model over the next edge.
    always @(negedge clk) begin
        bit rd_exp, ov_exp, was_idle, was_rel, was_active;
        while (rdy_n < issued && rd_cyc[rdy_n] + LAT + 1 <= cyc) rdy_n++;
        rd_exp = active && issued < total && (issued - popped) < LAT + 2;
        ov_exp = rdy_n > popped;
        check("rd_en", rd_en, rd_exp);
        check("out_valid", st.out_valid, ov_exp);
        check("busy", busy, active);
        check("frame_done", frame_done, done_next);
        if (rd_exp && rd_en) check("data_addr", data_addr, addr_q[issued]);
        if (ov_exp && st.out_valid) begin
            int a;
            a = addr_q[popped];
            check("out_data", st.out_data, mem_val(a));
            check("out_sens", st.out_sens, a / (GRID * GRID));
            check("out_last", st.out_last, popped == total - 1);
        end

        if (frame_done) done_cnt++;
        if (rd_en && first_rd < 0) first_rd = cyc;
        if (st.out_valid && first_ov < 0) first_ov = cyc;
        if (st.out_valid && st.out_ready) begin
            beats_seen++;
            if (st.out_last) last_cnt++;
        end
        dut_out += int'(rd_en) - int'(st.out_valid && st.out_ready);
        if (dut_out > max_out) max_out = dut_out;

        was_idle   = !active && !rel;
        was_rel    = rel;
        was_active = active;
        done_next  = 0;
        if (rst) begin
            active = 0; rel = 0; issued = 0; popped = 0; rdy_n = 0; total = 0;
            rd_cyc.delete();
            dut_out = 0;
        end else begin
            if (was_active) begin
                if (rd_exp) begin
                    rd_cyc.push_back(cyc);
                    issued++;
                end
                if (total == 0 || (ov_exp && st.out_ready && popped + 1 == total)) begin
                    active = 0; rel = 1; done_next = 1;
                end
                if (ov_exp && st.out_ready) popped++;
            end
            if (was_rel && !drdy) rel = 0;
            if (was_idle && drdy) begin
                build_frame(mode, int'(plane_row), sens_mask);
                active = 1; issued = 0; popped = 0; rdy_n = 0;
                rd_cyc.delete();
                first_rd = -1; first_ov = -1; max_out = 0; dut_out = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int pat, input int k);
        case (pat)
            0:       st.out_ready = 1'b1;
            1:       st.out_ready = (k % 3 == 0);
            3:       st.out_ready = !(k >= 100 && k < 120);
            default: st.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic run_frame(input int pat, input int budget, input string name);
        int d0, k;
        repeat (3) tick();
        d0 = done_cnt;
        k = 0;
        drdy = 1'b1;
        set_ready(pat, k);
        tick();
        drdy = 1'b0;
        while (done_cnt == d0 && k < budget) begin
            k++;
            if (k == 5) begin
                mode = 1'($urandom);
                plane_row = GW'($urandom);
            end
            set_ready(pat, k);
            tick();
        end
        check({name, " completed"}, int'(done_cnt != d0), 1);
        st.out_ready = 1'b1;
    endtask

    initial begin
        int b0, l0, d0, k, m;
        st.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset data_addr", data_addr, 0);
        check("reset rd_en", rd_en, 0);
        check("reset out_valid", st.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);

        mode = 1'b0; plane_row = 3;
        b0 = beats_seen; l0 = last_cnt; d0 = done_cnt;
        run_frame(0, 400, "plane");
        check("plane beats", beats_seen - b0, 64);
        check("plane model total", total, 64);
        check("plane model first addr", addr_q[0], 24);
        check("plane out_last count", last_cnt - l0, 1);
        check("plane frame_done count", done_cnt - d0, 1);
        check("plane first beat latency", first_ov - first_rd, LAT + 1);

        mode = 1'b1;
        b0 = beats_seen; l0 = last_cnt; d0 = done_cnt;
        run_frame(1, 3000, "full 1of3");
        check("full 1of3 beats", beats_seen - b0, 512);
        check("full model last addr", addr_q[511], 511);
        check("full 1of3 out_last count", last_cnt - l0, 1);
        check("full 1of3 frame_done count", done_cnt - d0, 1);

        mode = 1'b1;
        b0 = beats_seen;
        run_frame(3, 2000, "full stall");
        check("full stall beats", beats_seen - b0, 512);
        check("full stall max outstanding", max_out, LAT + 2);

        mode = 1'b0; plane_row = GW'($urandom);
        b0 = beats_seen; d0 = done_cnt;
        repeat (3) tick();
        drdy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            set_ready(2, i);
            tick();
        end
        check("drdy held frames", done_cnt - d0, 1);
        check("drdy held beats", beats_seen - b0, 64);
        drdy = 1'b0;
        mode = 1'b0;
        run_frame(2, 1000, "rearm");
        check("rearm frames", done_cnt - d0, 2);

        mode = 1'b1;
        b0 = beats_seen;
        repeat (3) tick();
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        k = 0;
        while (beats_seen - b0 < 30 && k < 300) begin
            tick();
            k++;
        end
        check("reached beat 30", int'(beats_seen - b0 >= 30), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset rd_en", rd_en, 0);
        check("mid reset out_valid", st.out_valid, 0);
        check("mid reset busy", busy, 0);
        check("mid reset data_addr", data_addr, 0);
        repeat (10) tick();
        mode = 1'b1;
        b0 = beats_seen;
        run_frame(0, 1000, "after reset");
        check("after reset beats", beats_seen - b0, 512);

        for (int i = 0; i < 4; i++) begin
            m = $urandom_range(0, 1);
            mode = 1'(m);
            plane_row = GW'($urandom);
            b0 = beats_seen;
            run_frame(2, 4000, "random");
            check("random beats", beats_seen - b0, (m != 0) ? 512 : 64);
        end

`ifdef TOF_SENS_MASK_EN
        sens_mask = 8'b1000_0001;
        mode = 1'b0; plane_row = 2;
        b0 = beats_seen;
        run_frame(2, 400, "mask 81");
        check("mask 81 beats", beats_seen - b0, 16);
        check("mask 81 model total", total, 16);
        sens_mask = '0;
        b0 = beats_seen; d0 = done_cnt;
        run_frame(0, 20, "mask 0");
        check("mask 0 beats", beats_seen - b0, 0);
        check("mask 0 frame_done count", done_cnt - d0, 1);
        sens_mask = '1;
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
